// File: rtl/miriscv_fetch.sv
// Instruction fetch stage: PC register feeding a 2-entry {pc, instr, fault} queue.
// Fetches outside the instruction-memory window are tagged, delivered, then halt fetching until a redirect.
module miriscv_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h7600_0000,
  parameter logic [23:0] IM_BASE_HI = 24'h760000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] im_addr_o,
  input  logic [31:0] im_rd_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_fault_o
);

  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic        halt_q, halt_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;

  logic [31:0] entry_pc_q    [2];
  logic [31:0] entry_instr_q [2];
  logic        entry_fault_q [2];

  logic pop;
  logic enq;
  logic fault_in;

  assign fault_in      = (pc_q[31:8] != IM_BASE_HI);
  assign instr_valid_o = (count_q != 2'd0);
  assign pop           = instr_valid_o & instr_ready_i;
  assign enq           = ~redirect_i & ~halt_q & ((count_q < 2'd2) | pop);

  assign im_addr_o     = pc_q;
  assign instr_o       = entry_instr_q[rd_ptr_q];
  assign instr_pc_o    = entry_pc_q[rd_ptr_q];
  assign instr_fault_o = entry_fault_q[rd_ptr_q];

  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    halt_d   = halt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    // A redirect flushes everything, including a head popped in the same cycle.
    if (redirect_i) begin
      pc_d     = {redirect_pc_i[31:2], 2'b00};
      count_d  = 2'd0;
      halt_d   = 1'b0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (enq) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = ~wr_ptr_q;
        if (fault_in) halt_d = 1'b1;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, enq} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q     <= RESET_PC;
      count_q  <= 2'd0;
      halt_q   <= 1'b0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      halt_q   <= halt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          entry_pc_q[gi]    <= 32'h0;
          entry_instr_q[gi] <= 32'h0;
          entry_fault_q[gi] <= 1'b0;
        end else if (enq && (wr_ptr_q == 1'(gi))) begin
          entry_pc_q[gi]    <= pc_q;
          entry_instr_q[gi] <= im_rd_i;
          entry_fault_q[gi] <= fault_in;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_miriscv_fetch.sv
// Directed bench for miriscv_fetch: one task per scenario, each with inline expected-value checks.
// Instruction memory is a 64-word array mapped at 0x76000000; addresses outside it read as zero.
module tb_miriscv_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] im_addr;
  logic [31:0] im_rd;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_fault;

  logic [31:0] mem [64];
  int pass_count = 0;
  int check_count = 0;

  miriscv_fetch dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .im_addr_o     (im_addr),
    .im_rd_i       (im_rd),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .instr_fault_o (instr_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    im_rd = 32'h0;
    if (im_addr[31:8] == 24'h760000) im_rd = mem[im_addr[7:2]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic ready);
    @(negedge clk);
    rst         = 1'b1;
    redirect    = 1'b0;
    instr_ready = ready;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect = 1'b0;
    instr_ready = 1'b1;
    #1;
    check_count++;
    if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", instr_valid);
    else pass_count++;
    check_count++;
    if (im_addr !== 32'h7600_0000) $display("FAIL reset_pc: got %08h expected 76000000", im_addr);
    else pass_count++;
    check_count++;
    if ({instr, instr_pc, instr_fault} !== 65'h0)
      $display("FAIL reset_head: got %08h/%08h/%0b expected 0/0/0", instr, instr_pc, instr_fault);
    else pass_count++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    check_count++;
    if (instr_valid !== 1'b0) $display("FAIL stream_pre_valid: got %0b expected 0", instr_valid);
    else pass_count++;
    for (int k = 0; k < 4; k++) begin
      step();
      $display("stream txn %0d: pc=%08h instr=%08h fault=%0b", k, instr_pc, instr, instr_fault);
      check_count++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h7600_0000 + 32'(4 * k) || instr !== mem[k] || instr_fault !== 1'b0)
        $display("FAIL stream_%0d: got v=%0b pc=%08h instr=%08h f=%0b expected v=1 pc=%08h instr=%08h f=0",
                 k, instr_valid, instr_pc, instr, instr_fault, 32'h7600_0000 + 32'(4 * k), mem[k]);
      else pass_count++;
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    repeat (5) step();
    check_count++;
    if (im_addr !== 32'h7600_0008) $display("FAIL bp_pc_stall: got %08h expected 76000008", im_addr);
    else pass_count++;
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      $display("backpressure txn %0d: pc=%08h instr=%08h", k, instr_pc, instr);
      check_count++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h7600_0000 + 32'(4 * k) || instr !== mem[k])
        $display("FAIL bp_head_%0d: got v=%0b pc=%08h instr=%08h expected v=1 pc=%08h instr=%08h",
                 k, instr_valid, instr_pc, instr, 32'h7600_0000 + 32'(4 * k), mem[k]);
      else pass_count++;
      step();
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    repeat (3) step();
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h7600_0043;
    step();
    redirect = 1'b0;
    check_count++;
    if (instr_valid !== 1'b0 || im_addr !== 32'h7600_0040)
      $display("FAIL redir_flush: got v=%0b addr=%08h expected v=0 addr=76000040", instr_valid, im_addr);
    else pass_count++;
    step();
    $display("redirect txn: pc=%08h instr=%08h", instr_pc, instr);
    check_count++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h7600_0040 || instr !== mem[16])
      $display("FAIL redir_first: got v=%0b pc=%08h instr=%08h expected v=1 pc=76000040 instr=%08h",
               instr_valid, instr_pc, instr, mem[16]);
    else pass_count++;
  endtask

  task automatic test_boundary();
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h7600_00F8;
    step();
    redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      $display("boundary txn %0d: pc=%08h instr=%08h fault=%0b", k, instr_pc, instr, instr_fault);
      check_count++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h7600_00F8 + 32'(4 * k) ||
          instr !== ((k == 2) ? 32'h0 : mem[62 + k]) || instr_fault !== (k == 2))
        $display("FAIL boundary_%0d: got v=%0b pc=%08h instr=%08h f=%0b expected pc=%08h f=%0b",
                 k, instr_valid, instr_pc, instr, instr_fault, 32'h7600_00F8 + 32'(4 * k), (k == 2));
      else pass_count++;
    end
    for (int k = 0; k < 4; k++) begin
      step();
      check_count++;
      if (instr_valid !== 1'b0 || im_addr !== 32'h7600_0104)
        $display("FAIL halted_%0d: got v=%0b addr=%08h expected v=0 addr=76000104", k, instr_valid, im_addr);
      else pass_count++;
    end
  endtask

  task automatic test_halt_redirect();
    redirect    = 1'b1;
    redirect_pc = 32'h7600_0010;
    step();
    redirect = 1'b0;
    step();
    $display("resume txn: pc=%08h instr=%08h fault=%0b", instr_pc, instr, instr_fault);
    check_count++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h7600_0010 || instr !== mem[4] || instr_fault !== 1'b0)
      $display("FAIL resume: got v=%0b pc=%08h instr=%08h f=%0b expected v=1 pc=76000010 instr=%08h f=0",
               instr_valid, instr_pc, instr, instr_fault, mem[4]);
    else pass_count++;
  endtask

  task automatic test_async_reset();
    do_reset(1'b0);
    repeat (2) step();
    check_count++;
    if (instr_valid !== 1'b1 || im_addr !== 32'h7600_0008)
      $display("FAIL areset_pre: got v=%0b addr=%08h expected v=1 addr=76000008", instr_valid, im_addr);
    else pass_count++;
    #2 rst = 1'b1;
    #1;
    check_count++;
    if (instr_valid !== 1'b0 || im_addr !== 32'h7600_0000 || instr !== 32'h0)
      $display("FAIL areset_clear: got v=%0b addr=%08h instr=%08h expected v=0 addr=76000000 instr=0",
               instr_valid, im_addr, instr);
    else pass_count++;
    #1 rst = 1'b0;
    @(negedge clk);
    check_count++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h7600_0000 || instr !== mem[0])
      $display("FAIL areset_first: got v=%0b pc=%08h instr=%08h expected v=1 pc=76000000 instr=%08h",
               instr_valid, instr_pc, instr, mem[0]);
    else pass_count++;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + 32'(i * 32'h111);
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_boundary();
    test_halt_redirect();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/miriscv_fetch.md
MIRISCV_FETCH -- requirements
Module: miriscv_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h7600_0000: PC value loaded on reset.
REQ-002 Parameter IM_BASE_HI, 24'h760000: required value of PC[31:8] for a legal fetch; the legal window is [0x76000000, 0x760000FC].
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 im_addr_o  output  32  fetch address to the instruction memory; equals the PC register.
REQ-006 im_rd_i  input  32  instruction word from the instruction memory, combinational from im_addr_o in the same cycle.
REQ-007 redirect_i  input  1  branch/jump/trap redirect request.
REQ-008 redirect_pc_i  input  32  redirect target address.
REQ-009 instr_valid_o  output  1  head entry of the fetch queue is valid.
REQ-010 instr_ready_i  input  1  downstream decoder accepts the head entry.
REQ-011 instr_o  output  32  head entry instruction word.
REQ-012 instr_pc_o  output  32  head entry PC.
REQ-013 instr_fault_o  output  1  head entry PC lay outside the legal window.

Function
REQ-014 The block SHALL hold a PC register, a 2-entry FIFO of {pc, instr, fault} entries, a 2-bit occupancy count (0..2) and a halt flag.
REQ-015 The block SHALL define pop = instr_valid_o & instr_ready_i.
REQ-016 The block SHALL define enq = ~redirect_i & ~halt & (count<2 | pop).
REQ-017 On enq, the block SHALL write {PC, im_rd_i, fault} at the FIFO tail, with fault = (PC[31:8] != IM_BASE_HI), and SHALL set PC <= PC + 4 (mod 2^32).
REQ-018 When no enq occurs and redirect_i = 0, PC SHALL hold its value.
REQ-019 Each entry SHALL appear on the outputs one cycle after its enq; instr_valid_o SHALL equal (count != 0).
REQ-020 instr_o, instr_pc_o and instr_fault_o SHALL be driven only from registered FIFO head state and SHALL remain stable while instr_valid_o = 1 and instr_ready_i = 0.
REQ-021 On simultaneous enq and pop with count = 2, occupancy SHALL stay 2, order SHALL be preserved, and no entry SHALL be lost or duplicated.
REQ-022 Entries SHALL be delivered strictly in enqueue order; the FIFO read/write pointers SHALL wrap modulo 2.
REQ-023 When an enqueued entry has fault = 1, the block SHALL set halt = 1 in the same edge, and no further enq SHALL occur until a redirect.
REQ-024 The faulting entry itself SHALL still be delivered, with instr_o = im_rd_i as sampled (32'h0 from the instruction memory).
REQ-025 When redirect_i = 1, on that edge the block SHALL empty the FIFO (count <= 0), clear halt, and set PC <= {redirect_pc_i[31:2], 2'b00}.
REQ-026 A redirect SHALL take priority over a simultaneous pop or enq; the popped head is considered consumed, and no entry is written that cycle.
REQ-027 The first post-redirect entry SHALL be enqueued on the following edge (instr_valid_o = 1 two edges after redirect_i is sampled).
REQ-028 Fetching at PC = 0x760000FC SHALL yield a legal entry; the next PC, 0x76000100, SHALL yield a fault entry and then halt.

Reset
REQ-029 While rst_i = 1, the block SHALL asynchronously set PC = RESET_PC, count = 0, halt = 0, instr_valid_o = 0, instr_o = 0, instr_pc_o = 0 and instr_fault_o = 0.
REQ-030 Reset asserted mid-operation SHALL discard all queued entries immediately.
REQ-031 On the first rising edge after rst_i deasserts, the block SHALL enqueue RESET_PC.

Verification
REQ-032 Reset release, instr_ready_i = 1 constant, memory[0..3] = A,B,C,D -> instr_valid_o rises 1 cycle after release; instr_pc_o sequence 0x76000000, 0x76000004, ... with instr_o A,B,C,D, one per cycle.
REQ-033 instr_ready_i = 0 for 5 cycles -> count saturates at 2, PC stops at 0x76000008, head holds 0x76000000/A; ready = 1 -> A, B, C delivered in order, no gaps after the first.
REQ-034 redirect_i = 1 with redirect_pc_i = 0x76000043 while the FIFO is full and a pop is in the same cycle -> next cycle instr_valid_o = 0; the following cycle head = 0x76000040 with memory[16].
REQ-035 redirect to 0x760000F8, ready = 1 -> entries 0x760000F8 and 0x760000FC (fault = 0), then 0x76000100 (fault = 1, instr_o = 0), then instr_valid_o = 0 indefinitely, with im_addr_o held at 0x76000104.
REQ-036 rst_i pulsed asynchronously (between edges) while 2 entries are queued -> instr_valid_o = 0 and im_addr_o = 0x76000000 before the next edge.
REQ-037 Redirect while halted -> halt clears and fetching resumes from the target.
